// File: rtl/rom_access_ctrl.sv
// ROM access controller for a multiplexed-bus CPU: latches the low address on ALE,
// decodes the ROM page range, inserts wait states and counts completed ROM reads.
module rom_access_ctrl #(
    parameter logic [7:0] ROM_BASE    = 8'h00,
    parameter int         ROM_PAGES   = 1,
    parameter int         WAIT_STATES = 1,
    parameter int         TIMEOUT     = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  AD,
    input  logic [7:0]  A,
    input  logic        ALE,
    input  logic        RDn,
    input  logic        WRn,
    input  logic        IO_Mn,
    output logic [7:0]  ADD,
    output logic        CSn,
    output logic        READY,
    output logic        WR_ERR,
    output logic        TO_ERR,
    output logic [15:0] ACC_CNT
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        DATA = 3'd3,
        WREJ = 3'd4
    } state_t;

    // Range bounds are 9 bits wide so a window touching page 8'hFF never wraps to page 0.
    localparam logic [8:0] PAGE_LO = {1'b0, ROM_BASE};
    localparam logic [8:0] PAGE_HI = PAGE_LO + 9'(ROM_PAGES);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] WS      = 3'(WAIT_STATES);

    state_t      state_r;
    logic        hit_r;
    logic        strobe_seen_r;
    logic [7:0]  to_cnt_r;
    logic [2:0]  wait_cnt_r;
    logic        hit_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Memory-cycle decode of the high address byte against the ROM page window.
    always_comb begin
        hit_s = (IO_Mn == 1'b0) && ({1'b0, A} >= PAGE_LO) && ({1'b0, A} < PAGE_HI);
    end

    // Access sequencer; every output is a register so CSn and READY cannot glitch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= IDLE;
            ADD           <= 8'h00;
            CSn           <= 1'b1;
            READY         <= 1'b1;
            WR_ERR        <= 1'b0;
            TO_ERR        <= 1'b0;
            ACC_CNT       <= 16'h0000;
            hit_r         <= 1'b0;
            strobe_seen_r <= 1'b0;
            to_cnt_r      <= 8'd0;
            wait_cnt_r    <= 3'd0;
        end else begin
            WR_ERR <= 1'b0;
            TO_ERR <= 1'b0;
            if (ALE) begin
                ADD           <= AD;
                hit_r         <= hit_s;
                to_cnt_r      <= 8'd0;
                strobe_seen_r <= 1'b0;
                CSn           <= 1'b1;
                READY         <= 1'b1;
                state_r       <= ADDR;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    ADDR: begin
                        // A simultaneous RDn/WRn is resolved as a write.
                        if (hit_r && !WRn) begin
                            WR_ERR  <= 1'b1;
                            state_r <= WREJ;
                        end else if (hit_r && !RDn) begin
                            CSn <= 1'b0;
                            if (WS == 3'd0) begin
                                state_r <= DATA;
                            end else begin
                                READY      <= 1'b0;
                                wait_cnt_r <= WS;
                                state_r    <= WAIT;
                            end
                        end else if (!RDn || !WRn) begin
                            strobe_seen_r <= 1'b1;
                            to_cnt_r      <= 8'd0;
                        end else if (strobe_seen_r) begin
                            state_r <= IDLE;
                        end else if (to_cnt_r == TO_LAST) begin
                            TO_ERR  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            to_cnt_r <= to_cnt_r + 8'd1;
                        end
                    end
                    WAIT: begin
                        if (RDn) begin
                            CSn        <= 1'b1;
                            READY      <= 1'b1;
                            wait_cnt_r <= 3'd0;
                            state_r    <= IDLE;
                        end else if (wait_cnt_r == 3'd1) begin
                            READY      <= 1'b1;
                            wait_cnt_r <= 3'd0;
                            state_r    <= DATA;
                        end else begin
                            wait_cnt_r <= wait_cnt_r - 3'd1;
                        end
                    end
                    DATA: begin
                        if (RDn) begin
                            CSn     <= 1'b1;
                            ACC_CNT <= sat_inc(ACC_CNT);
                            state_r <= IDLE;
                        end
                    end
                    WREJ: begin
                        if (WRn) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        CSn     <= 1'b1;
                        READY   <= 1'b1;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_access_ctrl.sv
// Randomized bench for rom_access_ctrl: three instances (0, 1 and 3 wait states, one with a
// page window at the top of the address map) share stimulus and are checked against bus-timing rules.
module tb_rom_access_ctrl;

    logic        CLK = 1'b0;
    logic        RESET, ALE, RDn, WRn, IO_Mn;
    logic [7:0]  AD, A;
    logic [7:0]  add_o    [3];
    logic        cs_o     [3];
    logic        rdy_o    [3];
    logic        wrerr_o  [3];
    logic        toerr_o  [3];
    logic [15:0] cnt_o    [3];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_cnt [3];
    logic [7:0]  model_add;

    always #5 CLK = ~CLK;

    rom_access_ctrl #(.ROM_BASE(8'h00), .ROM_PAGES(1), .WAIT_STATES(0), .TIMEOUT(15)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .AD(AD), .A(A), .ALE(ALE), .RDn(RDn), .WRn(WRn), .IO_Mn(IO_Mn),
        .ADD(add_o[0]), .CSn(cs_o[0]), .READY(rdy_o[0]), .WR_ERR(wrerr_o[0]), .TO_ERR(toerr_o[0]),
        .ACC_CNT(cnt_o[0]));
    rom_access_ctrl #(.ROM_BASE(8'h00), .ROM_PAGES(1), .WAIT_STATES(1), .TIMEOUT(15)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .AD(AD), .A(A), .ALE(ALE), .RDn(RDn), .WRn(WRn), .IO_Mn(IO_Mn),
        .ADD(add_o[1]), .CSn(cs_o[1]), .READY(rdy_o[1]), .WR_ERR(wrerr_o[1]), .TO_ERR(toerr_o[1]),
        .ACC_CNT(cnt_o[1]));
    rom_access_ctrl #(.ROM_BASE(8'hFE), .ROM_PAGES(4), .WAIT_STATES(3), .TIMEOUT(15)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .AD(AD), .A(A), .ALE(ALE), .RDn(RDn), .WRn(WRn), .IO_Mn(IO_Mn),
        .ADD(add_o[2]), .CSn(cs_o[2]), .READY(rdy_o[2]), .WR_ERR(wrerr_o[2]), .TO_ERR(toerr_o[2]),
        .ACC_CNT(cnt_o[2]));

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    // Instance 2 decodes pages FE..101, i.e. only FE and FF exist on the bus.
    function automatic bit hit_of(input int i, input logic [7:0] a_v, input logic io_v);
        int base;
        int pages;
        base  = (i == 2) ? 254 : 0;
        pages = (i == 2) ? 4 : 1;
        return (io_v == 1'b0) && (int'(a_v) >= base) && (int'(a_v) < base + pages);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input logic [2:0] e_cs, input logic [2:0] e_rdy,
                             input logic [2:0] e_wr, input logic [2:0] e_to);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("CSn[%0d]", i),     32'(cs_o[i]),    32'(e_cs[i]));
            check_eq($sformatf("READY[%0d]", i),   32'(rdy_o[i]),   32'(e_rdy[i]));
            check_eq($sformatf("WR_ERR[%0d]", i),  32'(wrerr_o[i]), 32'(e_wr[i]));
            check_eq($sformatf("TO_ERR[%0d]", i),  32'(toerr_o[i]), 32'(e_to[i]));
            check_eq($sformatf("ADD[%0d]", i),     32'(add_o[i]),   32'(model_add));
            check_eq($sformatf("ACC_CNT[%0d]", i), 32'(cnt_o[i]),   32'(model_cnt[i]));
        end
    endtask

    task automatic step(input logic rst, input logic ale_v, input logic [7:0] ad_v,
                        input logic [7:0] a_v, input logic rd_v, input logic wr_v, input logic io_v);
        RESET = rst; ALE = ale_v; AD = ad_v; A = a_v; RDn = rd_v; WRn = wr_v; IO_Mn = io_v;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // kind: 0 read, 1 write, 2 read+write together, 3 no strobe. Strobe held len cycles,
    // then gap idle cycles; gap 0 means the next ALE arrives on the release cycle.
    task automatic txn(input int kind, input int len, input int gap,
                       input logic [7:0] ad_v, input logic [7:0] a_v, input logic io_v);
        logic [2:0] e_cs, e_rdy, e_wr, e_to;
        logic       rd_l, wr_l;
        bit         h;
        int         w;
        step(1'b0, 1'b1, ad_v, a_v, 1'b1, 1'b1, io_v);
        model_add = ad_v;
        check_all(3'b111, 3'b111, 3'b000, 3'b000);
        rd_l = !(kind == 0 || kind == 2);
        wr_l = !(kind == 1 || kind == 2);
        for (int k = 1; k <= len + gap; k++) begin
            if (k <= len) step(1'b0, 1'b0, 8'($urandom), a_v, rd_l, wr_l, io_v);
            else          step(1'b0, 1'b0, 8'($urandom), a_v, 1'b1, 1'b1, io_v);
            for (int i = 0; i < 3; i++) begin
                w = ws_of(i);
                h = hit_of(i, a_v, io_v);
                e_cs[i] = 1'b1; e_rdy[i] = 1'b1; e_wr[i] = 1'b0; e_to[i] = 1'b0;
                if (kind == 0 && h) begin
                    e_cs[i]  = !(k <= len);
                    e_rdy[i] = !(k <= len && k <= w);
                    if (k == len + 1 && len >= w + 1 && model_cnt[i] < 65535) model_cnt[i]++;
                end
                if ((kind == 1 || kind == 2) && h) e_wr[i] = (k == 1);
                if (kind == 3) e_to[i] = (k == 15);
            end
            check_all(e_cs, e_rdy, e_wr, e_to);
        end
    endtask

    initial begin
        int kind, len, gap;
        logic [7:0] a_v;
        logic io_v;
        for (int i = 0; i < 3; i++) model_cnt[i] = 0;
        model_add = 8'h00;

        // Reset overrides a simultaneous ALE.
        step(1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);
        check_all(3'b111, 3'b111, 3'b000, 3'b000);

        // Reset in the middle of a 3-wait-state read on instance 2.
        step(1'b0, 1'b1, 8'h3C, 8'hFE, 1'b1, 1'b1, 1'b0);
        model_add = 8'h3C;
        check_all(3'b111, 3'b111, 3'b000, 3'b000);
        step(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b1, 1'b0);
        check_all(3'b011, 3'b011, 3'b000, 3'b000);
        step(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b1, 1'b0);
        check_all(3'b011, 3'b011, 3'b000, 3'b000);
        step(1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b1, 1'b0);
        model_add = 8'h00;
        check_all(3'b111, 3'b111, 3'b000, 3'b000);
        step(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'hFE, 1'b1, 1'b1, 1'b0);
        check_all(3'b111, 3'b111, 3'b000, 3'b000);

        // Directed bus cycles: reads, write to ROM, misses, I/O, timeout edges, abandon.
        txn(0, 4, 2, 8'h3C, 8'h00, 1'b0);
        txn(1, 2, 1, 8'hAA, 8'h00, 1'b0);
        txn(0, 3, 1, 8'h11, 8'h40, 1'b0);
        txn(0, 3, 1, 8'h22, 8'h00, 1'b1);
        txn(3, 15, 0, 8'h33, 8'h00, 1'b0);
        txn(3, 14, 0, 8'h44, 8'hFF, 1'b0);
        txn(2, 2, 1, 8'h55, 8'hFF, 1'b0);
        txn(0, 6, 0, 8'h5A, 8'hFE, 1'b0);
        txn(0, 5, 1, 8'hA5, 8'h00, 1'b0);

        for (int t = 0; t < 40; t++) begin
            kind = (t == 39) ? 0 : int'($urandom_range(0, 5));
            if (kind > 3) kind = 0;
            case ($urandom_range(0, 5))
                0:       a_v = 8'h00;
                1:       a_v = 8'h01;
                2:       a_v = 8'hFE;
                3:       a_v = 8'hFF;
                4:       a_v = 8'h40;
                default: a_v = 8'($urandom);
            endcase
            io_v = ($urandom_range(0, 5) == 0);
            if (kind == 3) begin
                len = int'($urandom_range(12, 18));
                gap = 0;
            end else begin
                len = int'($urandom_range(1, 6));
                gap = ($urandom_range(0, 4) == 0 || t == 39) ? ((t == 39) ? 2 : 0)
                                                               : int'($urandom_range(1, 2));
            end
            txn(kind, len, gap, 8'($urandom), a_v, io_v);
        end

        // Counter saturation from a value just below the limit.
        force u_dut0.ACC_CNT = 16'hFFFD;
        force u_dut1.ACC_CNT = 16'hFFFD;
        force u_dut2.ACC_CNT = 16'hFFFD;
        @(posedge CLK);
        @(negedge CLK);
        release u_dut0.ACC_CNT;
        release u_dut1.ACC_CNT;
        release u_dut2.ACC_CNT;
        for (int i = 0; i < 3; i++) model_cnt[i] = 65533;
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        check_all(3'b111, 3'b111, 3'b000, 3'b000);
        for (int r = 0; r < 4; r++) begin
            txn(0, 5, 1, 8'($urandom), 8'h00, 1'b0);
            txn(0, 5, 1, 8'($urandom), 8'hFF, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
